// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver with event FIFO.
package ps2_pkg;

    // Frame decoder states
    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

    // Event layout: {release, extended, scancode[7:0]}
    localparam int unsigned PS2_EVT_W       = 10;
    localparam int unsigned PS2_EVT_REL_BIT = 9;
    localparam int unsigned PS2_EVT_EXT_BIT = 8;

    function automatic logic [PS2_EVT_W-1:0] ps2_make_evt(input logic       rel,
                                                          input logic       ext,
                                                          input logic [7:0] code);
        return {rel, ext, code};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side bus of the PS/2 receiver: event FIFO head, handshake and status.
interface ps2_rx_fifo_if
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) ();

    logic                              clear;
    logic                              ready;
    logic                              valid;
    logic [PS2_EVT_W-1:0]              code;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   count;
    logic                              overflow;
    logic                              frame_err;

    // Receiver side
    modport master (
        input  clear,
        input  ready,
        output valid,
        output code,
        output count,
        output overflow,
        output frame_err
    );

    // Consumer side
    modport slave (
        output clear,
        output ready,
        input  valid,
        input  code,
        input  count,
        input  overflow,
        input  frame_err
    );

endinterface

// File: rtl/ps2_debounce.sv
// Two-flop synchroniser followed by a stability filter; the output only moves
// after the synchronised input has disagreed with it for DEBOUNCE_CYCLES cycles.
module ps2_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]      sync_q, sync_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;

    // Count consecutive disagreeing cycles; flip the level on the last one
    always_comb begin
        sync_d  = {sync_q[0], i_raw};
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // State registers; lines idle high
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign o_level = level_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: filtered pins, 11-bit frame decoder with watchdog,
// E0/F0 prefix folding and an event FIFO drained by valid/ready.
// Optional parity checking is enabled by defining PS2_RX_PARITY_CHECK_EN.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 20000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ps2_clk,
    input  logic          i_ps2_data,
    ps2_rx_fifo_if.master bus
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_f, data_f, fall;

    ps2_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clk (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_raw  (i_ps2_clk),
        .o_level(clk_f)
    );

    ps2_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_data (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_raw  (i_ps2_data),
        .o_level(data_f)
    );

    // ---------------- Frame decoder ----------------
    ps2_state_e     state_q;
    logic [2:0]     bit_cnt_q;
    logic [7:0]     shift_q;
    logic [7:0]     byte_q;
    logic           byte_vld_q;
    logic           ferr_q;
    logic           clk_prev_q;
    logic [WdW-1:0] wd_q;
    logic           stop_ok;

    assign fall = clk_prev_q & ~clk_f;

`ifdef PS2_RX_PARITY_CHECK_EN
    logic par_ok_q;
    assign stop_ok = data_f & par_ok_q;
`else
    assign stop_ok = data_f;
`endif

    // Frame FSM with watchdog; byte/error outputs are single-cycle registered pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            ferr_q     <= 1'b0;
            clk_prev_q <= 1'b1;
            wd_q       <= '0;
`ifdef PS2_RX_PARITY_CHECK_EN
            par_ok_q   <= 1'b0;
`endif
        end else begin
            clk_prev_q <= clk_f;
            byte_vld_q <= 1'b0;
            ferr_q     <= 1'b0;
            if (bus.clear) begin
                state_q <= StIdle;
                wd_q    <= '0;
            end else if (state_q != StIdle && !fall && wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
                state_q <= StIdle;
                ferr_q  <= 1'b1;
                wd_q    <= '0;
            end else begin
                if (state_q != StIdle) begin
                    wd_q <= fall ? '0 : wd_q + WdW'(1);
                end
                if (fall) begin
                    unique case (state_q)
                        StIdle: begin
                            if (!data_f) begin
                                state_q   <= StData;
                                bit_cnt_q <= '0;
                                wd_q      <= '0;
                            end
                        end
                        StData: begin
                            shift_q   <= {data_f, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= StParity;
                            end
                        end
                        StParity: begin
`ifdef PS2_RX_PARITY_CHECK_EN
                            par_ok_q <= ^{shift_q, data_f};
`endif
                            state_q  <= StStop;
                        end
                        StStop: begin
                            state_q <= StIdle;
                            if (stop_ok) begin
                                byte_vld_q <= 1'b1;
                                byte_q     <= shift_q;
                            end else begin
                                ferr_q <= 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // ---------------- Prefix assembler + FIFO ----------------
    logic                 ext_q, ext_d, rel_q, rel_d;
    logic                 evt_vld;
    logic [PS2_EVT_W-1:0] evt;
    logic [PS2_EVT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [PS2_EVT_W-1:0] code_q, code_d;
    logic                 full, pop, push, drop;

    // Fold prefixes into flags; any other byte becomes an event
    always_comb begin
        ext_d   = ext_q;
        rel_d   = rel_q;
        evt_vld = 1'b0;
        evt     = ps2_make_evt(rel_q, ext_q, byte_q);
        if (bus.clear || ferr_q) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end else if (byte_vld_q) begin
            if (byte_q == PS2_PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (byte_q == PS2_PREFIX_REL) begin
                rel_d = 1'b1;
            end else begin
                evt_vld = 1'b1;
                ext_d   = 1'b0;
                rel_d   = 1'b0;
            end
        end
    end

    // FIFO bookkeeping; clear wins, a push into a full FIFO is kept if a pop frees a slot
    always_comb begin
        full    = (count_q == CntW'(FIFO_DEPTH));
        pop     = (count_q != '0) && bus.ready;
        push    = evt_vld && (!full || pop);
        drop    = evt_vld && full && !pop;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        code_d  = '0;
        if (bus.clear) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            wr_d    = wr_q + PtrW'(push);
            rd_d    = rd_q + PtrW'(pop);
            count_d = count_q + CntW'(push) - CntW'(pop);
            ovf_d   = ovf_q | drop;
            // Next head comes from the bypass when it is the entry being written now
            if (count_d != '0) begin
                code_d = (push && wr_q == rd_d) ? evt : mem_q[rd_d];
            end
        end
    end

    // Storage array; needs no reset since entries are only read once written
    always_ff @(posedge i_clk) begin
        if (push && !bus.clear) begin
            mem_q[wr_q] <= evt;
        end
    end

    // Assembler flags and FIFO control registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ext_q   <= 1'b0;
            rel_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            ext_q   <= ext_d;
            rel_q   <= rel_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            code_q  <= code_d;
        end
    end

    assign bus.valid     = (count_q != '0);
    assign bus.code      = code_q;
    assign bus.count     = count_q;
    assign bus.overflow  = ovf_q;
    assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: pin-level PS/2 frames against a queue-based event model.
module tb_ps2_rx_fifo;
    import ps2_pkg::*;

    localparam int unsigned DB    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TO    = 300;
    localparam int unsigned HALF  = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2c = 1'b1;
    logic ps2d = 1'b1;

    always #5 clk = ~clk;

    ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ps2_rx_fifo #(
        .DEBOUNCE_CYCLES(DB),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_ps2_clk (ps2c),
        .i_ps2_data(ps2d),
        .bus       (bus)
    );

    // Behavioural model
    logic [9:0] mq[$];
    bit         m_ext, m_rel, m_ovf;
    int         seen_err;
    int         n_chk, n_fail;
    bit         chk_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    function automatic bit parity_accepted(input logic [7:0] b, input logic p);
`ifdef PS2_RX_PARITY_CHECK_EN
        return (^{b, p}) == 1'b1;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            m_ext = 0;
            m_rel = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_rel = 1;
        end else begin
            if (mq.size() < DEPTH) mq.push_back({m_rel, m_ext, b});
            else m_ovf = 1;
            m_ext = 0;
            m_rel = 0;
        end
    endtask

    // Consumer pops as seen by the model
    always @(posedge clk) begin
        if (!rst && bus.ready && mq.size() > 0) mq.pop_front();
    end

    // Count error pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (!rst && bus.frame_err) seen_err <= seen_err + 1;
    end

    // Per-cycle comparison against the model while the DUT is settled
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("valid", 32'(bus.valid), 32'(mq.size() != 0));
            check("count", 32'(bus.count), 32'(mq.size()));
            if (mq.size() > 0) check("code", 32'(bus.code), 32'(mq[0]));
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
        end
    end

    // bits[0] is the start bit; data changes while the clock is high
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2d = bits[i];
            repeat (HALF) @(negedge clk);
            ps2c = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        int e0;
        bit ok;
        chk_en = 0;
        e0 = seen_err;
        send_bits({stop, par, b, 1'b0}, 11);
        repeat (30) @(negedge clk);
        ok = stop && parity_accepted(b, par);
        model_byte(b, ok);
        check("frame_err_pulses", 32'(seen_err - e0), ok ? 32'd0 : 32'd1);
        chk_en = 1;
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, odd_par(b), 1'b1);
    endtask

    task automatic pop_n(input int n);
        @(negedge clk);
        bus.ready = 1'b1;
        repeat (n) @(negedge clk);
        bus.ready = 1'b0;
    endtask

    task automatic do_clear();
        chk_en = 0;
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        mq.delete();
        m_ovf = 0;
        m_ext = 0;
        m_rel = 0;
        chk_en = 1;
    endtask

    initial begin
        int e0;
        logic [7:0] b;
        logic       par;
        logic       stop;
        bus.ready = 1'b0;
        bus.clear = 1'b0;
        n_chk = 0;
        n_fail = 0;
        seen_err = 0;
        chk_en = 0;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_code", 32'(bus.code), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk_en = 1;

        // Single make code
        send_good(8'h16);
        check("lit_016", 32'(bus.code), 32'h016);
        check("lit_cnt1", 32'(bus.count), 32'd1);
        pop_n(1);
        check("lit_empty", 32'(bus.valid), 32'd0);

        // Prefix folding
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h74);
        check("lit_374_cnt", 32'(bus.count), 32'd1);
        check("lit_374", 32'(bus.code), 32'h374);
        pop_n(1);
        send_good(8'h1C);
        check("lit_01c", 32'(bus.code), 32'h01C);
        pop_n(1);

        // Overflow and ordering
        for (int i = 1; i <= DEPTH + 1; i++) send_good(8'(i));
        check("lit_full_cnt", 32'(bus.count), DEPTH);
        check("lit_ovf", 32'(bus.overflow), 32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            check("lit_order", 32'(bus.code), 32'(i));
            pop_n(1);
        end
        send_good(8'h05);
        do_clear();
        check("lit_clr_ovf", 32'(bus.overflow), 32'd0);
        check("lit_clr_cnt", 32'(bus.count), 32'd0);

        // Bad parity, then bad stop bit
        send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_RX_PARITY_CHECK_EN
        check("lit_par_nopush", 32'(bus.valid), 32'd0);
`else
        check("lit_par_ignored", 32'(bus.code), 32'h01C);
`endif
        send_frame(8'h1C, 1'b0, 1'b0);
        pop_n(2);

        // Short clock glitch with data low must not start a frame
        chk_en = 0;
        e0 = seen_err;
        ps2d = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2c = 1'b0;
        repeat (3) @(negedge clk);
        ps2c = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2d = 1'b1;
        repeat (TO + 50) @(negedge clk);
        check("glitch_no_err", 32'(seen_err - e0), 32'd0);
        chk_en = 1;

        // Watchdog abort also drops a pending prefix
        send_good(8'hE0);
        chk_en = 0;
        e0 = seen_err;
        send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
        repeat (TO + 50) @(negedge clk);
        check("timeout_err", 32'(seen_err - e0), 32'd1);
        m_ext = 0;
        m_rel = 0;
        chk_en = 1;
        send_good(8'h29);
        check("lit_029", 32'(bus.code), 32'h029);
        pop_n(1);

        // Randomised traffic
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 9))
                0: b = 8'hE0;
                1: b = 8'hF0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            par  = odd_par(b) ^ ($urandom_range(0, 7) == 0);
            stop = ($urandom_range(0, 15) != 0);
            send_frame(b, par, stop);
            if ($urandom_range(0, 2) == 0) pop_n($urandom_range(1, 4));
            if ($urandom_range(0, 19) == 0) do_clear();
        end

        // Reset in the middle of a frame
        do_clear();
        send_good(8'h33);
        chk_en = 0;
        send_bits({1'b1, 1'b0, 8'h16, 1'b0}, 5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.valid), 32'd0);
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_code", 32'(bus.code), 32'd0);
        check("mid_rst_ovf", 32'(bus.overflow), 32'd0);
        check("mid_rst_ferr", 32'(bus.frame_err), 32'd0);
        mq.delete();
        m_ovf = 0;
        m_ext = 0;
        m_rel = 0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk_en = 1;
        send_good(8'h16);
        check("lit_after_rst", 32'(bus.code), 32'h016);
        check("lit_after_rst_cnt", 32'(bus.count), 32'd1);

        chk_en = 0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 keyboard receiver: next-generation replacement for the single-register PS/2 scancode capture. Filters the raw PS/2 clock and data lines and decodes 11-bit frames with start/stop checking and an optional parity check. Folds E0/F0 prefix bytes into one key event and queues events in a FIFO drained with a valid/ready handshake. Sits between the board PS/2 pins and the keyboard-consuming logic.

## Interface
- DEBOUNCE_CYCLES, 8: consecutive stable cycles before a filtered line changes level (≥2).
- FIFO_DEPTH, 8: event entries; power of two, ≥2.
- TIMEOUT_CYCLES, 20000: idle cycles inside a frame before abort (> 2·DEBOUNCE_CYCLES).
- i_clk  in  1  system clock; single clock domain.
- i_rst  in  1  asynchronous, active-high reset.
- i_ps2_clk  in  1  raw PS/2 clock, asynchronous, idles high.
- i_ps2_data  in  1  raw PS/2 data, asynchronous, idles high.
- i_clear  in  1  synchronous flush: empties FIFO, clears sticky flags, aborts frame, clears prefix flags.
- i_ready  in  1  consumer accepts head entry.
- o_valid  out  1  FIFO non-empty.
- o_code  out  10  head entry {release, extended, scancode[7:0]}.
- o_count  out  $clog2(FIFO_DEPTH+1)  occupancy.
- o_overflow  out  1  sticky: an event was dropped because FIFO was full.
- o_frame_err  out  1  one-cycle pulse per rejected/aborted frame.

## Operation
- Each raw line: 2-flop synchroniser, then debouncer; filtered level changes only after synced input differs for DEBOUNCE_CYCLES consecutive cycles. Filtered levels reset to 1.
- Bit sampled on filtered i_ps2_clk falling edge, using filtered data.
- Frame FSM: IDLE → DATA (8 bits, LSB first, 3-bit counter) → PARITY → STOP → IDLE.
  - IDLE: falling edge with data=0 → DATA; data=1 ignored.
  - STOP: data=1 and parity accepted → byte delivered to assembler; otherwise o_frame_err pulse, byte discarded.
- Watchdog: outside IDLE, counter resets on every filtered falling edge; reaching TIMEOUT_CYCLES → IDLE, o_frame_err pulse, prefix flags cleared.
- Assembler: 0xE0 sets extended; 0xF0 sets release; any other byte pushes {release, extended, byte} and clears both flags. A frame error also clears both flags.
- FIFO push when assembler emits and FIFO not full, or full with a pop in the same cycle (push accepted). Full without pop: event dropped, o_overflow set.
- Pop when o_valid && i_ready. Pop on empty is ignored.
- i_clear has priority over push/pop in the same cycle.
- Reset: o_valid=0, o_code=0, o_count=0, o_overflow=0, o_frame_err=0, FSM IDLE, flags clear, FIFO pointers 0. Reset mid-frame discards the partial frame.

## Timing
- Stop-bit raw falling edge → o_valid high (empty FIFO): at most DEBOUNCE_CYCLES+6 cycles.
- o_valid/o_code update the cycle after a push; o_code registered, stable while o_valid && !i_ready.
- Back-to-back pops: one entry per cycle; o_count reflects each push/pop the following cycle.
- o_overflow set the cycle after the drop; cleared only by i_clear or reset.
- Glitches shorter than DEBOUNCE_CYCLES produce no edge.

## Configuration
- PS2_RX_PARITY_CHECK_EN defined: parity bit must make the 9 bits odd; mismatch → frame error.
- Undefined: parity bit clocked and ignored; only start and stop bits checked.

## Structure
- Package ps2_pkg: FSM state enum; PS2_PREFIX_EXT = 8'hE0 and PS2_PREFIX_REL = 8'hF0; event width constant (10) and field positions.
- Sub-module ps2_debounce (synchroniser + stability counter, parameter DEBOUNCE_CYCLES), instantiated twice. FIFO kept inline.

## Test plan
- Reset, send 0x16 (parity 0), 12 cycles per half-period, data changed while clk high → o_valid=1, o_code=10'h016, o_count=1; pop → o_valid=0.
- Send E0, F0, 74 → exactly one entry, o_code=10'h374; then 1C → 10'h01C.
- i_ready=0, send FIFO_DEPTH+1 bytes 0x01.. → o_count=FIFO_DEPTH, o_overflow=1; pops return 0x01..0x08 in order; i_clear → o_overflow=0, o_count=0.
- 0x1C with parity 1 → macro defined: o_frame_err pulse, no push; undefined: o_code=10'h01C. Stop bit 0 → frame error either way.
- 3-cycle low glitch on i_ps2_clk → no bit. 4 bits then stall past TIMEOUT_CYCLES → o_frame_err; next full 0x29 → o_code=10'h029.
- Assert i_rst mid-frame → all outputs 0 immediately; after release, 0x16 received correctly.
